halt_dump_unit: RTL

HALT_DUMP_UNIT -- requirements
Module: halt_dump_unit

---
 rtl/halt_dump_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/halt_dump_unit.sv
// Halt detector and data-memory dumper: on the halt instruction it freezes the
// pipeline, drains, then streams DEPTH words over a valid/ready port.
// Optional running checksum output enabled by macro HALT_DUMP_CHECKSUM_EN.
module halt_dump_unit #(
  parameter int          DEPTH        = 512,
  parameter int          AW           = 9,
  parameter logic [31:0] HALT_INSTR   = 32'hffffffff,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_m,
  output logic          halted,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rd_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [31:0]   dump_data,
  output logic          dump_last,
`ifdef HALT_DUMP_CHECKSUM_EN
  output logic          done,
  output logic [31:0]   checksum
`else
  output logic          done
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_drain_cnt;
  logic [3:0]    w_next_drain_cnt;
  logic [AW-1:0] r_addr_cnt;
  logic [AW-1:0] w_next_addr_cnt;
  logic          r_halted;
  logic          r_dump_valid;
  logic          r_done;
  logic          w_handshake;
  logic          w_at_last;

  assign w_handshake = r_dump_valid & dump_ready;
  assign w_at_last   = (r_addr_cnt == AW'(DEPTH - 1));

  // Next-state, drain counter and address counter logic
  always_comb begin
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;
    w_next_addr_cnt  = r_addr_cnt;
    case (r_state)
      IDLE: begin
        if (instr_m == HALT_INSTR) begin
          w_next_state     = DRAIN;
          w_next_drain_cnt = 4'(DRAIN_CYCLES);
        end else begin
          w_next_state = IDLE;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 4'd0) begin
          w_next_state = DUMP;
        end else begin
          w_next_drain_cnt = r_drain_cnt - 4'd1;
        end
      end
      DUMP: begin
        // The final word parks the counter on DEPTH-1 instead of wrapping.
        if (w_handshake && w_at_last) begin
          w_next_state = DONE;
        end else if (w_handshake) begin
          w_next_addr_cnt = r_addr_cnt + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          w_next_addr_cnt = r_addr_cnt;
        end
      end
      DONE: begin
        w_next_state = DONE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State and registered output flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_drain_cnt  <= 4'd0;
      r_addr_cnt   <= {AW{1'b0}};
      r_halted     <= 1'b0;
      r_dump_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_drain_cnt  <= w_next_drain_cnt;
      r_addr_cnt   <= w_next_addr_cnt;
      r_halted     <= (w_next_state != IDLE);
      r_dump_valid <= (w_next_state == DUMP);
      r_done       <= (w_next_state == DONE);
    end
  end

  assign halted      = r_halted;
  assign dump_valid  = r_dump_valid;
  assign done        = r_done;
  assign dump_addr   = r_addr_cnt;
  assign mem_rd_addr = r_dump_valid ? r_addr_cnt : {AW{1'b0}};
  assign dump_data   = mem_rd_data;
  assign dump_last   = r_dump_valid & w_at_last;

`ifdef HALT_DUMP_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running sum of accepted words, restarted at each new halt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= 32'd0;
    end else if ((r_state == IDLE) && (w_next_state == DRAIN)) begin
      r_checksum <= 32'd0;
    end else if (w_handshake) begin
      r_checksum <= r_checksum + mem_rd_data;
    end else begin
      r_checksum <= r_checksum;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule
